// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-index definitions for the register-file scoreboard.
package regfile_scoreboard_pkg;
  localparam int REG_IDX_W = 5;
  localparam int REG_NUM   = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t X0_IDX = '0;

  // Decoded per-register strobe; x0 is hardwired and never tracked.
  function automatic logic [REG_NUM-1:0] reg_onehot(input reg_idx_t idx, input logic en);
    logic [REG_NUM-1:0] v;
    v = '0;
    if (en && idx != X0_IDX) v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/regfile_scoreboard_cnt.sv
// Per-register pending-write counter: +1 on issue, -1 on writeback, cleared by flush.
module regfile_scoreboard_cnt #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic zero,
  output logic max,
  output logic underflow
);
  logic [CNT_W-1:0] count;

  assign zero      = (count == '0);
  assign max       = &count;
  assign underflow = dec & zero & ~clr;

  // NOTE: state uses non-blocking assignments and a synchronous reset, so every
  // counter samples the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !zero) begin
      count <= count - 1'b1;
    end else if (inc && dec && zero) begin
      // The writeback had nothing to retire, so only the new write remains.
      count <= CNT_W'(1);
    end
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Issue hazard controller: tracks in-flight writes per register, blocks RAW/WAW issue.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_issue_valid,
  input  logic [4:0]        i_issue_rs1,
  input  logic              i_issue_rs1_ren,
  input  logic [4:0]        i_issue_rs2,
  input  logic              i_issue_rs2_ren,
  input  logic [4:0]        i_issue_rd,
  input  logic              i_issue_rd_wen,
  output logic              o_issue_ready,
  input  logic              i_wb_valid,
  input  logic [4:0]        i_wb_rd,
  input  logic              i_flush,
  output logic              o_stall_raw,
  output logic              o_stall_waw,
  output logic [31:0]       o_busy,
  output logic              o_underflow,
  output logic [PERF_W-1:0] o_stall_cycles
);
  logic [REG_NUM-1:0] zero_vec, max_vec, uf_vec, inc_vec, dec_vec;
  logic raw, waw, fire, stall_en;

  assign zero_vec[0] = 1'b1;
  assign max_vec[0]  = 1'b0;
  assign uf_vec[0]   = 1'b0;

  for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
    regfile_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_vec[r]),
      .dec       (dec_vec[r]),
      .clr       (i_flush),
      .zero      (zero_vec[r]),
      .max       (max_vec[r]),
      .underflow (uf_vec[r])
    );
  end

  assign o_busy = ~zero_vec;

  // Hazards look only at current counts; a same-cycle writeback does not clear them.
  assign raw = (i_issue_rs1_ren && o_busy[i_issue_rs1])
             | (i_issue_rs2_ren && o_busy[i_issue_rs2]);
  assign waw = i_issue_rd_wen && max_vec[i_issue_rd];

  assign o_issue_ready = ~rst & ~i_flush & ~raw & ~waw;
  assign o_stall_raw   = i_issue_valid & raw & ~i_flush & ~rst;
  assign o_stall_waw   = i_issue_valid & waw & ~i_flush & ~rst;

  assign fire    = i_issue_valid & o_issue_ready;
  assign inc_vec = reg_onehot(reg_idx_t'(i_issue_rd), fire & i_issue_rd_wen);
  assign dec_vec = reg_onehot(reg_idx_t'(i_wb_rd), i_wb_valid);

  assign stall_en = i_issue_valid & ~o_issue_ready & ~i_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_underflow    <= 1'b0;
      o_stall_cycles <= '0;
    end else begin
      if (|uf_vec) o_underflow <= 1'b1;
      if (stall_en && !(&o_stall_cycles)) o_stall_cycles <= o_stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard with hand-computed expectations.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rs1;
  logic        i_issue_rs1_ren;
  logic [4:0]  i_issue_rs2;
  logic        i_issue_rs2_ren;
  logic [4:0]  i_issue_rd;
  logic        i_issue_rd_wen;
  logic        o_issue_ready;
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd;
  logic        i_flush;
  logic        o_stall_raw;
  logic        o_stall_waw;
  logic [31:0] o_busy;
  logic        o_underflow;
  logic [31:0] o_stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.CNT_W(2), .PERF_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_issue_valid   (i_issue_valid),
    .i_issue_rs1     (i_issue_rs1),
    .i_issue_rs1_ren (i_issue_rs1_ren),
    .i_issue_rs2     (i_issue_rs2),
    .i_issue_rs2_ren (i_issue_rs2_ren),
    .i_issue_rd      (i_issue_rd),
    .i_issue_rd_wen  (i_issue_rd_wen),
    .o_issue_ready   (o_issue_ready),
    .i_wb_valid      (i_wb_valid),
    .i_wb_rd         (i_wb_rd),
    .i_flush         (i_flush),
    .o_stall_raw     (o_stall_raw),
    .o_stall_waw     (o_stall_waw),
    .o_busy          (o_busy),
    .o_underflow     (o_underflow),
    .o_stall_cycles  (o_stall_cycles)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_issue_valid = 0; i_issue_rs1 = 0; i_issue_rs1_ren = 0;
    i_issue_rs2 = 0; i_issue_rs2_ren = 0; i_issue_rd = 0; i_issue_rd_wen = 0;
    i_wb_valid = 0; i_wb_rd = 0; i_flush = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic rs1_ren, input logic [4:0] rs2,
                       input logic rs2_ren, input logic [4:0] rd, input logic rd_wen);
    i_issue_valid = 1; i_issue_rs1 = rs1; i_issue_rs1_ren = rs1_ren;
    i_issue_rs2 = rs2; i_issue_rs2_ren = rs2_ren; i_issue_rd = rd; i_issue_rd_wen = rd_wen;
  endtask

  task automatic wb(input logic [4:0] rd);
    i_wb_valid = 1; i_wb_rd = rd;
  endtask

  initial begin
    idle();
    rst = 1;
    issue(5'd5, 1, 5'd0, 0, 5'd0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", o_issue_ready, 0);
      check("rst_stall_raw", o_stall_raw, 0);
      check("rst_busy", o_busy, 0);
      check("rst_stall_cycles", o_stall_cycles, 0);
    end
    rst = 0;
    #1;
    check("idle_ready", o_issue_ready, 1);

    // Basic RAW on x5
    tick();
    issue(5'd0, 0, 5'd0, 0, 5'd5, 1);
    #1 check("raw_prod_ready", o_issue_ready, 1);
    tick();
    check("raw_busy5", o_busy, 32'h0000_0020);
    issue(5'd5, 1, 5'd0, 0, 5'd0, 0);
    #1;
    check("raw_stall", o_stall_raw, 1);
    check("raw_ready0", o_issue_ready, 0);
    tick();
    tick();
    wb(5'd5);
    #1 check("raw_ready_wb_cycle", o_issue_ready, 0);
    tick();
    i_wb_valid = 0;
    #1;
    check("raw_ready_after_wb", o_issue_ready, 1);
    check("raw_stall_cleared", o_stall_raw, 0);
    check("raw_stall_cycles", o_stall_cycles, 3);
    tick();
    idle();

    // WAW saturation on x7
    issue(5'd0, 0, 5'd0, 0, 5'd7, 1);
    for (int i = 0; i < 3; i++) begin
      #1 check("waw_fill_ready", o_issue_ready, 1);
      tick();
    end
    check("waw_busy7", o_busy[7], 1);
    check("waw_stall", o_stall_waw, 1);
    check("waw_ready0", o_issue_ready, 0);
    wb(5'd7);
    #1 check("waw_ready_wb_cycle", o_issue_ready, 0);
    tick();
    i_wb_valid = 0;
    #1;
    check("waw_ready_after_wb", o_issue_ready, 1);
    check("waw_stall_cleared", o_stall_waw, 0);
    check("waw_stall_cycles", o_stall_cycles, 4);
    tick();
    idle();
    wb(5'd7);
    tick(); tick(); tick();
    i_wb_valid = 0;
    check("waw_drained", o_busy[7], 0);
    check("waw_no_underflow", o_underflow, 0);

    // Simultaneous issue and writeback to x3 holding count 1
    issue(5'd0, 0, 5'd0, 0, 5'd3, 1);
    tick();
    wb(5'd3);
    #1 check("sim_ready", o_issue_ready, 1);
    tick();
    idle();
    check("sim_busy3", o_busy[3], 1);
    check("sim_no_underflow", o_underflow, 0);
    wb(5'd3);
    tick();
    idle();
    check("sim_count_was_one", o_busy[3], 0);
    check("sim_no_underflow2", o_underflow, 0);

    // x0 never tracked, then underflow on x9
    issue(5'd0, 1, 5'd0, 1, 5'd0, 1);
    #1;
    check("x0_ready", o_issue_ready, 1);
    check("x0_stall_raw", o_stall_raw, 0);
    tick();
    check("x0_busy", o_busy, 0);
    idle();
    wb(5'd0);
    tick();
    check("x0_wb_no_underflow", o_underflow, 0);
    wb(5'd9);
    tick();
    idle();
    check("uf_set", o_underflow, 1);
    check("uf_busy", o_busy, 0);
    tick(); tick();
    check("uf_sticky", o_underflow, 1);
    check("uf_stall_cycles_hold", o_stall_cycles, 4);

    // Reset clears sticky state, then flush mid-operation
    rst = 1;
    tick();
    rst = 0;
    check("rst2_underflow", o_underflow, 0);
    check("rst2_stall_cycles", o_stall_cycles, 0);
    issue(5'd0, 0, 5'd0, 0, 5'd4, 1);
    tick();
    i_issue_rd = 5'd6;
    tick();
    tick();
    idle();
    check("fl_pending", o_busy, 32'h0000_0050);
    issue(5'd0, 0, 5'd0, 0, 5'd8, 1);
    wb(5'd4);
    i_flush = 1;
    #1;
    check("fl_ready0", o_issue_ready, 0);
    check("fl_stall_raw", o_stall_raw, 0);
    check("fl_stall_waw", o_stall_waw, 0);
    tick();
    idle();
    check("fl_busy", o_busy, 0);
    check("fl_busy8", o_busy[8], 0);
    check("fl_no_underflow", o_underflow, 0);
    check("fl_stall_cycles", o_stall_cycles, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
